// File: rtl/spi_slave_param_if.sv
// SPI pin and user-handshake bundle for spi_slave_param.
// slave modport is the DUT view; master modport is the driving side.
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sck;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              busy;
  logic              rx_ovr;
  logic              ovr_clr;

  modport slave (
    input  sck, ss, mosi, tx_data, tx_load, rx_ack, ovr_clr,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, rx_ovr
  );

  modport master (
    output sck, ss, mosi, tx_data, tx_load, rx_ack, ovr_clr,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, rx_ovr
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave, fully synchronous to clk.
// sck/ss/mosi are oversampled through SYNC_STAGES flops; sck edges are found
// by comparing the synchronised sck with its registered copy.
// Optional macro SPI_SLAVE_LSB_FIRST_EN: both shift registers run LSB first.
module spi_slave_param #(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  spi_slave_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q,  sck_prev_d;

  logic [DATA_W-1:0] hold_q,     hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ovr_q,   rx_ovr_d;
  logic              miso_q,     miso_d;
  logic              miso_oe_q,  miso_oe_d;
  logic              busy_q,     busy_d;

  logic              sck_s_c, ss_s_c, mosi_s_c;
  logic              sck_edge_c, lead_c, trail_c, sample_c, shift_c;
  logic              word_done_c, ovr_set_c, sel_c;
  logic [DATA_W-1:0] rx_in_c, tx_adv_c;
  logic              tx_bit_c;

  // synchronised pin views and sck edge classification
  assign sck_s_c    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s_c     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s_c   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_edge_c = sck_s_c ^ sck_prev_q;
  assign lead_c     = sck_edge_c & (sck_prev_q == CPOL);
  assign trail_c    = sck_edge_c & (sck_s_c == CPOL);
  assign sample_c   = CPHA ? trail_c : lead_c;
  assign shift_c    = CPHA ? lead_c  : trail_c;

  // synchroniser shift chains and sck history
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  bus.sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   bus.ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sck_prev_d  = sck_s_c;
  end

  // bit-order dependent shift paths
`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_in_c  = {mosi_s_c, rx_shift_q[DATA_W-1:1]};
  assign tx_adv_c = {1'b0, tx_shift_q[DATA_W-1:1]};
  assign tx_bit_c = tx_shift_d[0];
`else
  assign rx_in_c  = {rx_shift_q[DATA_W-2:0], mosi_s_c};
  assign tx_adv_c = {tx_shift_q[DATA_W-2:0], 1'b0};
  assign tx_bit_c = tx_shift_d[DATA_W-1];
`endif

  // next-state, datapath and handshake logic
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tx_ready_d  = tx_ready_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    word_done_c = 1'b0;
    ovr_set_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ss_s_c) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = hold_q;
        bit_cnt_d  = '0;
        tx_ready_d = 1'b1;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        if (bit_cnt_q == CNT_W'(DATA_W)) begin
          word_done_c = 1'b1;
          state_d     = ss_s_c ? IDLE : LOAD;
        end else if (ss_s_c) begin
          state_d = IDLE;
        end else begin
          if (sample_c) begin
            rx_shift_d = rx_in_c;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          // the very first shift edge of a CPHA=1 word presents bit 0 unshifted
          if (shift_c && (bit_cnt_q != '0)) tx_shift_d = tx_adv_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // a load is accepted only into a free holding register
    if (bus.tx_load && tx_ready_q) begin
      hold_d     = bus.tx_data;
      tx_ready_d = 1'b0;
    end

    if (bus.rx_ack) rx_valid_d = 1'b0;
    if (word_done_c) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      ovr_set_c  = rx_valid_q & ~bus.rx_ack;
    end

    if (bus.ovr_clr) rx_ovr_d = 1'b0;
    if (ovr_set_c)   rx_ovr_d = 1'b1;
  end

  // pin-side outputs: driven from LOAD onwards until the slave drops back to IDLE
  always_comb begin
    sel_c     = (state_q != IDLE) && (state_d != IDLE);
    miso_oe_d = sel_c;
    miso_d    = sel_c ? tx_bit_c : 1'b0;
    busy_d    = (state_d == ACTIVE);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: mode-0 (a) and mode-3 (b) slaves driven by a
// behavioural SPI master; expectations come from a word-level model.
module tb_spi_slave_param;

  localparam int unsigned S    = 2;
  localparam int unsigned HALF = 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0] sck_m = 2'b10, ss_m = 2'b11, mosi_m = 2'b00;
  logic [1:0] tx_load_m = 2'b00, rx_ack_m = 2'b00, ovr_clr_m = 2'b00;
  logic [7:0] tx_data_m [2];
  logic [1:0] miso_m, oe_m, tx_ready_m, rx_valid_m, busy_m, rx_ovr_m;
  logic [7:0] rx_data_m [2];

  // word-level model: value the slave will send next and whether it is free
  logic [7:0] m_hold  [2];
  bit         m_ready [2];

  spi_slave_param_if #(.DATA_W(8)) if_a ();
  spi_slave_param_if #(.DATA_W(8)) if_b ();

  spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  spi_slave_param #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  assign if_a.sck = sck_m[0];     assign if_b.sck = sck_m[1];
  assign if_a.ss = ss_m[0];       assign if_b.ss = ss_m[1];
  assign if_a.mosi = mosi_m[0];   assign if_b.mosi = mosi_m[1];
  assign if_a.tx_data = tx_data_m[0]; assign if_b.tx_data = tx_data_m[1];
  assign if_a.tx_load = tx_load_m[0]; assign if_b.tx_load = tx_load_m[1];
  assign if_a.rx_ack = rx_ack_m[0];   assign if_b.rx_ack = rx_ack_m[1];
  assign if_a.ovr_clr = ovr_clr_m[0]; assign if_b.ovr_clr = ovr_clr_m[1];
  assign miso_m     = {if_b.miso, if_a.miso};
  assign oe_m       = {if_b.miso_oe, if_a.miso_oe};
  assign tx_ready_m = {if_b.tx_ready, if_a.tx_ready};
  assign rx_valid_m = {if_b.rx_valid, if_a.rx_valid};
  assign busy_m     = {if_b.busy, if_a.busy};
  assign rx_ovr_m   = {if_b.rx_ovr, if_a.rx_ovr};
  assign rx_data_m[0] = if_a.rx_data;
  assign rx_data_m[1] = if_b.rx_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk(input bit sel);
    chk("rst_miso",     32'(miso_m[sel]),     32'd0);
    chk("rst_miso_oe",  32'(oe_m[sel]),       32'd0);
    chk("rst_rx_data",  32'(rx_data_m[sel]),  32'd0);
    chk("rst_rx_valid", 32'(rx_valid_m[sel]), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready_m[sel]), 32'd1);
    chk("rst_busy",     32'(busy_m[sel]),     32'd0);
    chk("rst_rx_ovr",   32'(rx_ovr_m[sel]),   32'd0);
  endtask

  // mode 0: idle; 1: pulse rx_ack in the completion cycle; 2: check rx_valid latency
  task automatic half_wait(input bit sel, input int mode);
    for (int j = 1; j <= int'(HALF); j++) begin
      @(negedge clk);
      if (mode == 1) rx_ack_m[sel] = (j == int'(S) + 1);
      if (mode == 2 && j == int'(S) + 1) chk("lat_before", 32'(rx_valid_m[sel]), 32'd0);
      if (mode == 2 && j == int'(S) + 2) chk("lat_valid",  32'(rx_valid_m[sel]), 32'd1);
    end
  endtask

  task automatic try_load(input bit sel, input logic [7:0] v);
    tx_data_m[sel] = v;
    tx_load_m[sel] = 1'b1;
    @(negedge clk);
    tx_load_m[sel] = 1'b0;
    if (m_ready[sel]) begin
      m_hold[sel]  = v;
      m_ready[sel] = 1'b0;
    end
    chk("tx_ready_low", 32'(tx_ready_m[sel]), 32'd0);
  endtask

  task automatic ss_begin(input bit sel);
    ss_m[sel] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_end(input bit sel);
    half_wait(sel, 0);
    ss_m[sel] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_ack(input bit sel);
    rx_ack_m[sel] = 1'b1;
    @(negedge clk);
    rx_ack_m[sel] = 1'b0;
    @(negedge clk);
    chk("ack_clears", 32'(rx_valid_m[sel]), 32'd0);
  endtask

  // one master word; slave b is CPOL=1/CPHA=1, slave a is mode 0
  task automatic spi_word(input bit sel, input logic [7:0] w, input int nbits, input int end_mode);
    logic [7:0] rd;
    logic [7:0] exp_tx;
    int idx;
    int md;
    exp_tx = m_hold[sel];
    m_ready[sel] = 1'b1;
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = LSB ? i : 7 - i;
      md  = (i == nbits - 1) ? end_mode : 0;
      if (!sel) begin
        mosi_m[sel] = w[idx];
        half_wait(sel, 0);
        sck_m[sel] = 1'b1;
        rd[idx] = miso_m[sel];
        half_wait(sel, md);
        sck_m[sel] = 1'b0;
      end else begin
        sck_m[sel] = 1'b0;
        mosi_m[sel] = w[idx];
        half_wait(sel, 0);
        sck_m[sel] = 1'b1;
        rd[idx] = miso_m[sel];
        half_wait(sel, md);
      end
    end
    if (nbits == 8) chk("miso_word", 32'(rd), 32'(exp_tx));
  endtask

  task automatic rx_chk(input bit sel, input logic [7:0] d, input bit ovr);
    chk("rx_data",  32'(rx_data_m[sel]),  32'(d));
    chk("rx_valid", 32'(rx_valid_m[sel]), 32'd1);
    chk("rx_ovr",   32'(rx_ovr_m[sel]),   32'(ovr));
  endtask

  initial begin
    bit sel;
    logic [7:0] h, d;
    tx_data_m[0] = '0; tx_data_m[1] = '0;
    for (int k = 0; k < 2; k++) begin m_hold[k] = '0; m_ready[k] = 1'b1; end

    repeat (3) @(negedge clk);
    reset_chk(1'b0);
    reset_chk(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // mode 0 basic word with latency check
    try_load(1'b0, 8'h3C);
    ss_begin(1'b0);
    chk("t1_oe",   32'(oe_m[0]),   32'd1);
    chk("t1_busy", 32'(busy_m[0]), 32'd1);
    spi_word(1'b0, 8'hA5, 8, 2);
    ss_end(1'b0);
    rx_chk(1'b0, 8'hA5, 1'b0);
    chk("t1_idle_busy", 32'(busy_m[0]), 32'd0);
    chk("t1_idle_oe",   32'(oe_m[0]),   32'd0);
    chk("t1_idle_miso", 32'(miso_m[0]), 32'd0);
    pulse_ack(1'b0);

    // CPOL=1 CPHA=1
    try_load(1'b1, 8'hC3);
    ss_begin(1'b1);
    spi_word(1'b1, 8'h5A, 8, 0);
    ss_end(1'b1);
    rx_chk(1'b1, 8'h5A, 1'b0);
    pulse_ack(1'b1);

    // back-to-back words with a load during word 1 and an ignored second load
    try_load(1'b0, 8'h66);
    ss_begin(1'b0);
    fork
      spi_word(1'b0, 8'h11, 8, 0);
      begin
        repeat (30) @(negedge clk);
        chk("t3_ready_w1", 32'(tx_ready_m[0]), 32'd1);
        try_load(1'b0, 8'h77);
        try_load(1'b0, 8'h99);
      end
    join
    chk("t3_ready_w2", 32'(tx_ready_m[0]), 32'd1);
    rx_chk(1'b0, 8'h11, 1'b0);
    pulse_ack(1'b0);
    spi_word(1'b0, 8'h22, 8, 0);
    ss_end(1'b0);
    rx_chk(1'b0, 8'h22, 1'b0);
    pulse_ack(1'b0);

    // overrun, clear, then ack coincident with completion
    ss_begin(1'b0);
    spi_word(1'b0, 8'h33, 8, 0);
    spi_word(1'b0, 8'h44, 8, 0);
    ss_end(1'b0);
    rx_chk(1'b0, 8'h44, 1'b1);
    ovr_clr_m[0] = 1'b1;
    @(negedge clk);
    ovr_clr_m[0] = 1'b0;
    @(negedge clk);
    rx_chk(1'b0, 8'h44, 1'b0);
    ss_begin(1'b0);
    spi_word(1'b0, 8'h55, 8, 1);
    ss_end(1'b0);
    rx_chk(1'b0, 8'h55, 1'b0);
    pulse_ack(1'b0);

    // abort after 5 bits, then a full word
    ss_begin(1'b0);
    spi_word(1'b0, 8'hFF, 5, 0);
    ss_end(1'b0);
    chk("t5_no_valid", 32'(rx_valid_m[0]), 32'd0);
    chk("t5_busy",     32'(busy_m[0]),     32'd0);
    chk("t5_oe",       32'(oe_m[0]),       32'd0);
    ss_begin(1'b0);
    spi_word(1'b0, 8'h81, 8, 0);
    ss_end(1'b0);
    rx_chk(1'b0, 8'h81, 1'b0);
    pulse_ack(1'b0);

    // randomized words on both slaves
    for (int n = 0; n < 6; n++) begin
      sel = 1'($urandom_range(0, 1));
      h   = 8'($urandom);
      d   = 8'($urandom);
      try_load(sel, h);
      ss_begin(sel);
      spi_word(sel, d, 8, 0);
      ss_end(sel);
      rx_chk(sel, d, 1'b0);
      pulse_ack(sel);
    end

    // reset mid-word
    try_load(1'b0, 8'h5C);
    ss_begin(1'b0);
    spi_word(1'b0, 8'hAA, 4, 0);
    rst = 1'b0;
    #1;
    reset_chk(1'b0);
    reset_chk(1'b1);
    @(negedge clk);
    ss_m[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin m_hold[k] = '0; m_ready[k] = 1'b1; end
    repeat (3) @(negedge clk);
    try_load(1'b0, 8'hE7);
    ss_begin(1'b0);
    spi_word(1'b0, 8'hF0, 8, 0);
    ss_end(1'b0);
    rx_chk(1'b0, 8'hF0, 1'b0);
    pulse_ack(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised, fully synchronous SPI slave that generalises the fixed-width spi_slave.
- Configurable word width and SPI mode (CPOL/CPHA).
- SPI pins are oversampled in the system clock domain; no logic is clocked by sck or by a ready strobe.
- Valid/ack handshakes on both the TX and RX user sides.
- Sits between the board pin map (JA/vaux pins) and application logic such as LED capture or register files.

Parameters:
DATA_W, 8, bits per SPI word (2..32).
CPOL, 0, sck idle level.
CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing.
SYNC_STAGES, 2, synchroniser depth for sck/ss/mosi (>=2).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
sck  in  1  SPI clock from master; must be <= clk/8.
ss  in  1  slave select, active low.
mosi  in  1  master-out data.
miso  out  1  slave-out data; 0 while deselected.
miso_oe  out  1  high while selected; for an external tristate.
tx_data  in  DATA_W  next word to transmit.
tx_load  in  1  writes tx_data into the holding register when tx_ready=1.
tx_ready  out  1  holding register free.
rx_data  out  DATA_W  last received word.
rx_valid  out  1  rx_data valid; held until acknowledged.
rx_ack  in  1  consumes rx_data.
busy  out  1  word transfer in progress.
rx_ovr  out  1  sticky overrun flag.
ovr_clr  in  1  clears rx_ovr.

Behaviour:
- Reset (rst low, async): miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, rx_ovr=0. FSM goes to IDLE; holding, shift and bit-count registers are cleared. Reset mid-transfer aborts the word silently.
- Synchronisation and edge detection:
  - sck, ss and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the synchronised sck with its registered copy.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- FSM states: IDLE, LOAD, ACTIVE.
- IDLE:
  - Entered on synchronised ss high; miso_oe=0 and busy=0.
  - Synchronised ss falling -> LOAD.
- LOAD (1 cycle):
  - tx shift register <= holding register; bit count <= 0.
  - tx_ready <= 1 if a word was pending.
  - miso_oe <= 1. For CPHA=0, the first bit drives miso at the end of this cycle.
  - Transition -> ACTIVE.
- ACTIVE:
  - busy=1.
  - On the sample edge: shift synchronised mosi into the rx shift register and increment the bit count.
  - On the shift edge: advance the tx shift register so miso shows the next bit.
  - For CPHA=1, the first leading edge outputs bit 0 and does not discard it.
- Word completion (count == DATA_W after a sample edge):
  - Next cycle: rx_data <= rx shift register and rx_valid <= 1.
  - FSM re-enters LOAD for back-to-back words while ss stays low.
- Bit order: MSB first by default.
- TX handshake:
  - tx_load with tx_ready=1 captures tx_data and drops tx_ready.
  - tx_load with tx_ready=0 is ignored.
  - With no new load, the holding register retains its value and is retransmitted.
- RX handshake:
  - rx_valid stays high until a cycle with rx_ack=1, then clears the following cycle.
  - If a word completes while rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, rx_ovr <= 1.
  - If completion and rx_ack coincide: the new word wins, rx_valid stays 1, and no overrun is flagged.
  - ovr_clr clears rx_ovr, unless an overrun occurs in the same cycle (set wins).
- Abort: ss high before count reaches DATA_W.
  - Partial word discarded; no rx_valid.
  - Holding register untouched if it was not yet consumed, otherwise already consumed.
  - FSM returns to IDLE.
- Master timing: the master waits >= SYNC_STAGES+3 clk cycles between ss falling and the first sck edge.
- Latency: last sample edge at the pin to rx_valid high = SYNC_STAGES+2 clk cycles.

Optional Feature:
- SPI_SLAVE_LSB_FIRST_EN defined: both shift registers operate LSB first, and rx_data bit 0 is the first bit received.
- Undefined: MSB first as described above.
- Handshakes and timing are identical in both cases.

Test Plan:
1. Mode 0, DATA_W=8, holding=0x3C. Master sends 0xA5 -> rx_data=0xA5, rx_valid=1, master reads 0x3C, rx_ovr=0.
2. CPOL=1, CPHA=1. Master sends 0x5A, holding=0xC3 -> rx_data=0x5A, master reads 0xC3.
3. ss held low for two words 0x11, 0x22 with tx_load of 0x77 during word 1 (holding=0x66 beforehand):
   - rx_valid pulses per word with rx_ack each time.
   - Master reads 0x66 then 0x77.
   - tx_ready re-asserts at the start of word 2.
4. Second word completes with no rx_ack -> rx_data=second word, rx_ovr=1. Then ovr_clr -> rx_ovr=0. Repeat with rx_ack coincident with completion -> rx_ovr stays 0.
5. ss raised after 5 of 8 bits -> no rx_valid, busy=0, FSM in IDLE. A following full 0x81 word is received correctly.
6. rst low mid-word -> all outputs at reset values immediately. After release, a 0xF0 transfer succeeds. Repeat tests 1–2 with SPI_SLAVE_LSB_FIRST_EN defined and mirrored values (send 0xA5 -> rx_data=0xA5 when bits are sent LSB first).
